// File: rtl/reg_file_sb.sv
// DEPTH x WIDTH register file with one synchronous write port, two combinational
// read ports (optional write bypass) and a per-entry pending scoreboard.
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              pend_a,
    output logic              pend_b,
    output logic              any_pend
);

    typedef struct packed {
        logic             pend;
        logic [WIDTH-1:0] data;
    } rd_port_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             wr_ok;
    logic             rsv_ok;
    logic             byp_ok;
    rd_port_t         port_a;
    rd_port_t         port_b;

    // Entry 0 swallows writes and reservations when it is hard-wired to zero.
    assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
    // Clear discards the write, so forwarding it would show data never stored.
    assign byp_ok = (BYPASS != 0) && wr_ok && !clear;

    // NOTE: the storage array is reset here on purpose; the reset contract says
    // every entry reads 0 immediately, so it cannot map to a plain RAM macro.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending <= '0;
        end else begin
            // NOTE: the reserve assignment follows the write one, so with
            // non-blocking semantics a same-address reserve overrides the
            // write's pending clear: the new producer wins.
            if (wr_ok) begin
                mem[wr_addr]     <= wr_data;
                pending[wr_addr] <= 1'b0;
            end
            if (rsv_ok) pending[rsv_addr] <= 1'b1;
        end
    end

    function automatic rd_port_t read_port(input logic [ADDR_W-1:0] addr);
        rd_port_t r;
        r.data = mem[addr];
        r.pend = pending[addr];
        if (byp_ok && wr_addr == addr) begin
            r.data = wr_data;
            r.pend = 1'b0;
        end
        if ((ZERO_REG != 0 && addr == '0) || !resetn) begin
            r.data = '0;
            r.pend = 1'b0;
        end
        return r;
    endfunction

    // NOTE: combinational read paths assign every output on every pass
    // (function return covers all fields), so no latch can be inferred.
    always_comb begin
        port_a = read_port(rd_addr_a);
        port_b = read_port(rd_addr_b);
    end

    assign rd_data_a = port_a.data;
    assign pend_a    = port_a.pend;
    assign rd_data_b = port_b.data;
    assign pend_b    = port_b.pend;
    assign any_pend  = |pending;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: three instances (bypass, no bypass, zero
// register) share one stimulus set and are checked against hand-computed values.
module tb_reg_file_sb;

    logic        clock = 1'b0;
    logic        resetn;
    logic        clear;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;

    logic [15:0] b_rda, b_rdb, n_rda, n_rdb, z_rda, z_rdb;
    logic        b_pa, b_pb, b_any, n_pa, n_pb, n_any, z_pa, z_pb, z_any;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    reg_file_sb #(.BYPASS(1), .ZERO_REG(0)) dut_byp (
        .clock(clock), .resetn(resetn), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(b_rda), .rd_data_b(b_rdb),
        .pend_a(b_pa), .pend_b(b_pb), .any_pend(b_any)
    );

    reg_file_sb #(.BYPASS(0), .ZERO_REG(0)) dut_nobyp (
        .clock(clock), .resetn(resetn), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(n_rda), .rd_data_b(n_rdb),
        .pend_a(n_pa), .pend_b(n_pb), .any_pend(n_any)
    );

    reg_file_sb #(.BYPASS(1), .ZERO_REG(1)) dut_zero (
        .clock(clock), .resetn(resetn), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(z_rda), .rd_data_b(z_rdb),
        .pend_a(z_pa), .pend_b(z_pb), .any_pend(z_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        clear  = 1'b0;
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; idle();
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        #12 resetn = 1'b1;
        tick();

        // Reset then idle
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            check($sformatf("rst_rda%0d", i), b_rda, 0);
            check($sformatf("rst_pa%0d", i), b_pa, 0);
            check($sformatf("rst_rdb%0d", i), n_rdb, 0);
        end
        check("rst_any", b_any, 0);
        tick();

        // Write 0xBEEF to addr 3
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr_a = 3'd3;
        #2;
        check("byp_same_data", b_rda, 16'hBEEF);
        check("byp_same_pend", b_pa, 0);
        check("nobyp_same_data", n_rda, 16'h0000);
        tick(); idle(); #2;
        check("byp_next_data", b_rda, 16'hBEEF);
        check("nobyp_next_data", n_rda, 16'hBEEF);

        // Reserve addr 5, then satisfy it with a write
        rsv_en = 1'b1; rsv_addr = 3'd5; rd_addr_b = 3'd5;
        #2;
        check("rsv_same_pend", b_pb, 0);
        check("rsv_same_any", b_any, 0);
        tick(); idle(); #2;
        check("rsv_next_pend", b_pb, 1);
        check("rsv_next_any", b_any, 1);
        check("rsv_nobyp_pend", n_pb, 1);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        #2;
        check("wr5_byp_pend", b_pb, 0);
        check("wr5_byp_data", b_rdb, 16'h1234);
        check("wr5_nobyp_pend", n_pb, 1);
        check("wr5_nobyp_data", n_rdb, 16'h0000);
        tick(); idle(); #2;
        check("wr5_next_any", b_any, 0);
        check("wr5_next_data", b_rdb, 16'h1234);

        // Same-cycle write and reserve on addr 2
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00AA;
        rsv_en = 1'b1; rsv_addr = 3'd2; rd_addr_a = 3'd2;
        tick(); idle(); #2;
        check("wrrsv_data", b_rda, 16'h00AA);
        check("wrrsv_pend", b_pa, 1);
        check("wrrsv_zero_pend", z_pa, 1);

        // Fill, reserve, then clear together with a write
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h1111 * i);
            tick();
        end
        idle();
        rsv_en = 1'b1; rsv_addr = 3'd1; tick();
        rsv_addr = 3'd6; tick(); idle();
        rd_addr_a = 3'd7; rd_addr_b = 3'd6; #2;
        check("fill_rd7", b_rda, 16'h7777);
        check("fill_pend6", b_pb, 1);
        check("fill_any", b_any, 1);
        clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hABCD;
        rsv_en = 1'b1; rsv_addr = 3'd3; rd_addr_a = 3'd4;
        #1;
        check("clr_same_rd4", b_rda, 16'h4444);
        tick(); idle();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); #1;
            check($sformatf("clr_rd%0d", i), b_rda, 0);
            check($sformatf("clr_pend%0d", i), b_pa, 0);
        end
        check("clr_any", b_any, 0);
        tick();

        // Refill, then an asynchronous reset pulse mid-cycle during a write
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h2222; rsv_en = 1'b1; rsv_addr = 3'd6;
        tick(); idle(); rd_addr_b = 3'd1; #1;
        check("refill_rd1", b_rdb, 16'h2222);
        check("refill_any", b_any, 1);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555; rd_addr_a = 3'd4;
        #1 resetn = 1'b0;
        #1;
        check("arst_rda", b_rda, 0);
        check("arst_rdb", b_rdb, 0);
        check("arst_any", b_any, 0);
        rd_addr_b = 3'd6; #1;
        check("arst_pb", b_pb, 0);
        idle(); resetn = 1'b1;
        tick(); #1;
        check("arst_after_rd4", b_rda, 0);
        check("arst_after_any", b_any, 0);

        // Zero register: write and reserve on addr 0
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 3'd0; rd_addr_a = 3'd0;
        #2;
        check("z_same_data", z_rda, 0);
        check("z_same_pend", z_pa, 0);
        check("z_ref_byp_data", b_rda, 16'hFFFF);
        tick(); idle(); #2;
        check("z_next_data", z_rda, 0);
        check("z_next_pend", z_pa, 0);
        check("z_next_any", z_any, 0);
        check("z_ref_data", b_rda, 16'hFFFF);
        check("z_ref_pend", b_pa, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-entry successor to the single enable register: a DEPTH-entry by WIDTH-bit register file with one synchronous write port, two asynchronous read ports with optional write-to-read bypass, and a per-entry pending scoreboard. It sits between the processor's decode stage (reads and reservations) and the writeback stage (writes). It provides the operand storage and the hazard flags that the control FSM uses to stall.

## Interface
- WIDTH, 16, data width of each entry
- DEPTH, 8, number of entries; must equal 2**ADDR_W
- ADDR_W, 3, address width
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads show stored value only
- ZERO_REG, 0, 1 = entry 0 is hard-wired to zero (writes and reservations to it ignored)

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all entries and pending bits
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- rsv_en  in  1  reserve strobe (mark entry pending)
- rsv_addr  in  ADDR_W  reserved address
- rd_addr_a / rd_addr_b  in  ADDR_W  read addresses
- rd_data_a / rd_data_b  out  WIDTH  read data (combinational)
- pend_a / pend_b  out  1  pending flag of the addressed entry (combinational)
- any_pend  out  1  OR of all pending bits

## Operation
- Storage: DEPTH x WIDTH regs plus DEPTH pending bits; all updated on the rising clock edge only.
- Priority at each edge: resetn low > clear > write/reserve.
- clear=1: all entries <= 0, all pending <= 0; wr_en and rsv_en are ignored that cycle.
- wr_en=1: entry[wr_addr] <= wr_data, and pending[wr_addr] <= 0.
- rsv_en=1: pending[rsv_addr] <= 1; entry data is unchanged.
- Write and reserve to the same address in the same cycle: data is written and pending ends at 1 (the new producer wins). Different addresses update independently.
- Write to a non-pending entry is legal; its pending bit stays 0.
- Reading:
  - rd_data_x = entry[rd_addr_x].
  - With BYPASS=1, wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data instead.
- Pending flag:
  - pend_x = pending[rd_addr_x].
  - With BYPASS=1, a same-cycle write to rd_addr_x forces pend_x = 0.
  - A same-cycle reservation does not affect pend_x; it is visible from the next cycle.
- Any read during clear=1 returns the pre-clear value (clear is not bypassed).
- ZERO_REG=1:
  - Address 0 reads 0 and pend 0.
  - wr_en and rsv_en to address 0 have no effect, and no bypass is applied to address 0.
- any_pend is the OR of the registered pending bits (no bypass).

## Timing
- Write latency: 1 edge. Data is visible on the read ports in the same cycle via bypass (BYPASS=1), otherwise after the edge.
- Reserve latency: 1 edge.
- Reset (async assert, any time including mid-write):
  - All entries and pending bits are 0 immediately.
  - rd_data_a/b = 0, pend_a/b = 0, any_pend = 0 while resetn is low.
- After resetn deasserts, the first edge may write.
- Read paths are purely combinational from registers and the write port. No other state exists; no FSM.

## Test plan
- Reset then idle: every read address 0..7 -> rd_data 0, pend 0, any_pend 0.
- Write 0xBEEF to addr 3, next cycle read A=3 -> 0xBEEF. With BYPASS=1, in the write cycle itself read A=3 -> 0xBEEF and pend_a=0. With BYPASS=0, in the write cycle read A=3 -> old value 0.
- Reserve addr 5 -> next cycle pend_b=1 at B=5 and any_pend=1. Write 0x1234 to addr 5 -> same cycle pend_b=0 (BYPASS=1) and rd_data_b=0x1234. Next cycle any_pend=0.
- Same-cycle write 0x00AA and reserve on addr 2 -> next cycle rd_data=0x00AA and pend=1.
- Fill all 8 entries with 0x1111*i, reserve addrs 1 and 6, pulse clear together with wr_en to addr 4 -> next cycle all entries 0, no pending, addr 4 still 0. Repeat with a resetn pulse mid-cycle -> outputs 0 immediately.
- ZERO_REG=1: write 0xFFFF and reserve on addr 0 -> rd_data 0 and pend 0 in both the same and the next cycle.
